// File: rtl/control_fsm_pkg.sv
// Shared types for the RV32I multi-cycle control path: FSM states, opcode
// constants, ALU operation classes and datapath mux-select encodings.
package control_fsm_pkg;

    typedef enum logic [1:0] {
        ALU_OP__MEMORY_ACCESS      = 2'b00,
        ALU_OP__BRANCH             = 2'b01,
        ALU_OP__REGISTER_OPERATION = 2'b10,
        ALU_OP__UNSET              = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_EXECUTE_I = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10
    } control_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        OPC_MEM     = 3'd0,
        OPC_R_TYPE  = 3'd1,
        OPC_I_TYPE  = 3'd2,
        OPC_BRANCH  = 3'd3,
        OPC_JAL     = 3'd4,
        OPC_ILLEGAL = 3'd5
    } opcode_class_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RESULT_ALU_OUT    = 2'b00,
        RESULT_MEM_DATA   = 2'b01,
        RESULT_ALU_RESULT = 2'b10
    } result_src_t;

endpackage

// File: rtl/opcode_classifier.sv
// Maps the raw 7-bit opcode onto the instruction class the control FSM
// branches on; anything unsupported is classed as illegal.
module opcode_classifier
    import control_fsm_pkg::*;
(
    input  logic [6:0]    opcode,
    output opcode_class_t op_class
);

    // Opcode to class lookup
    always_comb begin
        op_class = OPC_ILLEGAL;
        case (opcode)
            OP_LOAD, OP_STORE: op_class = OPC_MEM;
            OP_R_TYPE:         op_class = OPC_R_TYPE;
            OP_I_TYPE:         op_class = OPC_I_TYPE;
            OP_BRANCH:         op_class = OPC_BRANCH;
            OP_JAL:            op_class = OPC_JAL;
            default:           op_class = OPC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main control FSM for the RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives datapath selects and strobes.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       reg_write,
    output alu_op_t    alu_op,
    output logic       illegal_instr
);

    control_state_t state_r;
    control_state_t next_state_s;
    opcode_class_t  op_class_s;

    logic        mem_req_s, mem_write_s, adr_src_s, ir_write_s, pc_update_s;
    logic        branch_s, reg_write_s, illegal_instr_s;
    alu_src_a_t  alu_src_a_s;
    alu_src_b_t  alu_src_b_s;
    result_src_t result_src_s;
    alu_op_t     alu_op_s;

    opcode_classifier u_opcode_classifier (
        .opcode   (opcode),
        .op_class (op_class_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) next_state_s = S_DECODE;
                else           next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (op_class_s)
                    OPC_MEM:    next_state_s = S_MEM_ADR;
                    OPC_R_TYPE: next_state_s = S_EXECUTE_R;
                    OPC_I_TYPE: next_state_s = S_EXECUTE_I;
                    OPC_BRANCH: next_state_s = S_BRANCH;
                    OPC_JAL:    next_state_s = S_JAL;
                    default:    next_state_s = S_FETCH;
                endcase
            end
            S_MEM_ADR: begin
                if (opcode[5]) next_state_s = S_MEM_WRITE;
                else           next_state_s = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready) next_state_s = S_MEM_WB;
                else           next_state_s = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) next_state_s = S_FETCH;
                else           next_state_s = S_MEM_WRITE;
            end
            S_EXECUTE_R: next_state_s = S_ALU_WB;
            S_EXECUTE_I: next_state_s = S_ALU_WB;
            S_JAL:       next_state_s = S_ALU_WB;
            S_MEM_WB:    next_state_s = S_FETCH;
            S_ALU_WB:    next_state_s = S_FETCH;
            S_BRANCH:    next_state_s = S_FETCH;
            default:     next_state_s = S_FETCH;
        endcase
    end

    // Moore output decode; only the FETCH strobes look at mem_ready
    always_comb begin
        mem_req_s       = 1'b0;
        mem_write_s     = 1'b0;
        adr_src_s       = 1'b0;
        ir_write_s      = 1'b0;
        pc_update_s     = 1'b0;
        branch_s        = 1'b0;
        reg_write_s     = 1'b0;
        illegal_instr_s = 1'b0;
        alu_src_a_s     = SRC_A_PC;
        alu_src_b_s     = SRC_B_RS2;
        result_src_s    = RESULT_ALU_OUT;
        alu_op_s        = ALU_OP__MEMORY_ACCESS;
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = SRC_B_FOUR;
                result_src_s = RESULT_ALU_RESULT;
                ir_write_s   = mem_ready;
                pc_update_s  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s     = SRC_A_OLD_PC;
                alu_src_b_s     = SRC_B_IMM;
                illegal_instr_s = (op_class_s == OPC_ILLEGAL);
            end
            S_MEM_ADR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
            end
            S_MEM_READ: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
            end
            S_MEM_WB: begin
                result_src_s = RESULT_MEM_DATA;
                reg_write_s  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
            end
            S_EXECUTE_R: begin
                alu_src_a_s = SRC_A_RS1;
                alu_op_s    = ALU_OP__REGISTER_OPERATION;
            end
            S_EXECUTE_I: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                alu_op_s    = ALU_OP__UNSET;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = SRC_A_RS1;
                alu_op_s    = ALU_OP__BRANCH;
                branch_s    = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = SRC_A_OLD_PC;
                alu_src_b_s = SRC_B_FOUR;
                pc_update_s = 1'b1;
            end
            default: begin
                alu_src_b_s  = SRC_B_FOUR;
                result_src_s = RESULT_ALU_RESULT;
            end
        endcase
    end

    // Strobes are killed combinationally while reset is held, so a waiting
    // store is dropped in the same cycle reset asserts.
    assign mem_req       = mem_req_s       & rst_n;
    assign mem_write     = mem_write_s     & rst_n;
    assign ir_write      = ir_write_s      & rst_n;
    assign pc_update     = pc_update_s     & rst_n;
    assign branch        = branch_s        & rst_n;
    assign reg_write     = reg_write_s     & rst_n;
    assign illegal_instr = illegal_instr_s & rst_n;
    assign adr_src       = adr_src_s;
    assign alu_src_a     = alu_src_a_s;
    assign alu_src_b     = alu_src_b_s;
    assign result_src    = result_src_s;
    assign alu_op        = alu_op_s;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle output vectors compared against
// hand-derived expectations for each instruction class and reset case.
module tb_control_fsm;
    import control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0000000;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_update, branch;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       reg_write, illegal_instr;
    alu_op_t    alu_op;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_update     (pc_update),
        .branch        (branch),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .reg_write     (reg_write),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr)
    );

    // {mem_req,mem_write,adr_src,ir_write,pc_update,branch}_A_B_result_regwrite_aluop_illegal
    logic [15:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_update, branch,
                  alu_src_a, alu_src_b, result_src, reg_write, alu_op, illegal_instr};

    localparam logic [15:0] V_RESET  = 16'b000000_00_10_10_0_00_0;
    localparam logic [15:0] V_F_RDY  = 16'b100110_00_10_10_0_00_0;
    localparam logic [15:0] V_F_WAIT = 16'b100000_00_10_10_0_00_0;
    localparam logic [15:0] V_DEC    = 16'b000000_01_01_00_0_00_0;
    localparam logic [15:0] V_DEC_IL = 16'b000000_01_01_00_0_00_1;
    localparam logic [15:0] V_MADR   = 16'b000000_10_01_00_0_00_0;
    localparam logic [15:0] V_MRD    = 16'b101000_00_00_00_0_00_0;
    localparam logic [15:0] V_MWB    = 16'b000000_00_00_01_1_00_0;
    localparam logic [15:0] V_MWR    = 16'b111000_00_00_00_0_00_0;
    localparam logic [15:0] V_EXR    = 16'b000000_10_00_00_0_10_0;
    localparam logic [15:0] V_EXI    = 16'b000000_10_01_00_0_11_0;
    localparam logic [15:0] V_AWB    = 16'b000000_00_00_00_1_00_0;
    localparam logic [15:0] V_BR     = 16'b000001_10_00_00_0_01_0;
    localparam logic [15:0] V_JAL    = 16'b000010_01_10_00_0_00_0;

    task automatic test_reset();
        logic [15:0] exp [5];
        logic        rdy [5];
        exp = '{V_F_RDY, V_DEC, V_EXR, V_AWB, V_F_WAIT};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R_TYPE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (obs !== V_RESET) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, V_RESET);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i]; #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %b want %b", i + 1, obs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        logic [15:0] exp [9];
        logic        rdy [9];
        exp = '{V_F_RDY, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MRD, V_MWB, V_F_WAIT};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = OP_LOAD;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i]; #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL lw_wait cyc %0d: got %b want %b", i + 1, obs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_reset();
        logic [15:0] exp [5];
        logic        rdy [5];
        exp = '{V_F_RDY, V_DEC, V_MADR, V_MWR, V_MWR};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = OP_STORE;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i]; #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL sw_wait cyc %0d: got %b want %b", i + 1, obs, exp[i]);
            end
            @(negedge clk);
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if (obs !== V_RESET) begin
            n_fail++;
            $display("FAIL sw_reset_drop: got %b want %b", obs, V_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== V_F_WAIT) begin
            n_fail++;
            $display("FAIL sw_reset_refetch: got %b want %b", obs, V_F_WAIT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [5];
        logic        rdy [5];
        exp = '{V_F_RDY, V_DEC, V_MADR, V_MWR, V_F_WAIT};
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_STORE;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i]; #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL sw_back_to_back cyc %0d: got %b want %b", i + 1, obs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jal();
        logic [15:0] exp [9];
        logic        rdy [9];
        logic [6:0]  ops [9];
        exp = '{V_F_RDY, V_DEC, V_BR, V_F_RDY, V_DEC, V_JAL, V_AWB, V_F_WAIT, V_F_WAIT};
        rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ops = '{OP_BRANCH, OP_BRANCH, OP_BRANCH, OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_JAL};
        for (int i = 0; i < 9; i++) begin
            opcode = ops[i]; mem_ready = rdy[i]; #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL branch_jal cyc %0d: got %b want %b", i + 1, obs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_itype();
        logic [15:0] exp [10];
        logic        rdy [10];
        logic [6:0]  ops [10];
        exp = '{V_F_RDY, V_DEC_IL, V_F_WAIT, V_F_WAIT, V_F_RDY, V_DEC, V_EXI, V_AWB,
                V_F_WAIT, V_F_WAIT};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ops = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, OP_I_TYPE, OP_I_TYPE,
                OP_I_TYPE, OP_I_TYPE, OP_I_TYPE, OP_I_TYPE};
        for (int i = 0; i < 10; i++) begin
            opcode = ops[i]; mem_ready = rdy[i]; #1;
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL illegal_itype cyc %0d: got %b want %b", i + 1, obs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_sw_reset();
        test_back_to_back();
        test_branch_jal();
        test_illegal_itype();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
